// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encodings,
// requester indices and the default stall timeout.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int REQ_CMD = 0;
    localparam int REQ_EVT = 1;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    function automatic logic [1:0] idx_to_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_arb.sv
// Two-input winner select: a lone requester always wins; on a tie the
// winner is requester 0 (fixed priority) or whoever did not win last.
module rr_arbiter2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] i_valid,
    input  logic       i_last_winner,
    output logic       o_any,
    output logic       o_winner
);

    always_comb begin
        o_any    = |i_valid;
        o_winner = 1'b0;
        case (i_valid)
            2'b01:   o_winner = 1'b0;
            2'b10:   o_winner = 1'b1;
            2'b11:   o_winner = (FIXED_PRIO != 0) ? 1'b0 : ~i_last_winner;
            default: o_winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-granular scheduler that shares one UART transmitter between the
// command-response and event/report byte streams.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int FIXED_PRIO     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [1:0] req_last,
    output logic [1:0] req_ready,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_write_en,
    output logic [1:0] grant,
    output logic       stall_err,
    output logic [1:0] state_debug
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           r_state;
    logic [1:0]       r_grant;
    logic             r_gidx;
    logic             r_last_winner;
    logic             r_last;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [7:0]       r_tx_data;
    logic             r_tx_we;
    logic             r_stall_err;

    logic       w_any;
    logic       w_winner;
    logic       w_gvalid;
    logic [7:0] w_gdata;
    logic       w_glast;
    logic       w_fire;

    rr_arbiter2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .i_valid       (req_valid),
        .i_last_winner (r_last_winner),
        .o_any         (w_any),
        .o_winner      (w_winner)
    );

    assign w_gvalid = r_gidx ? req_valid[REQ_EVT] : req_valid[REQ_CMD];
    assign w_gdata  = r_gidx ? req_data1 : req_data0;
    assign w_glast  = r_gidx ? req_last[REQ_EVT] : req_last[REQ_CMD];
    assign w_fire   = (r_state == ST_SEND) && w_gvalid && tx_ready;

    // Ready is offered only to the owner and only while in SEND.
    always_comb begin
        req_ready = 2'b00;
        if (r_state == ST_SEND) begin
            req_ready = r_gidx ? {tx_ready, 1'b0} : {1'b0, tx_ready};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_grant       <= 2'b00;
            r_gidx        <= 1'b0;
            r_last_winner <= 1'b1;
            r_last        <= 1'b0;
            r_stall_cnt   <= '0;
            r_tx_data     <= 8'h00;
            r_tx_we       <= 1'b0;
            r_stall_err   <= 1'b0;
        end else begin
            r_tx_we     <= 1'b0;
            r_stall_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant     <= idx_to_onehot(w_winner);
                        r_gidx      <= w_winner;
                        r_stall_cnt <= '0;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_fire) begin
                        r_tx_data   <= w_gdata;
                        r_tx_we     <= 1'b1;
                        r_last      <= w_glast;
                        r_stall_cnt <= '0;
                        r_state     <= ST_HOLD;
                    end else if (!w_gvalid) begin
                        // Only an absent owner counts toward the timeout.
                        if (r_stall_cnt == CNT_MAX) begin
                            r_stall_err   <= 1'b1;
                            r_grant       <= 2'b00;
                            r_last_winner <= r_gidx;
                            r_stall_cnt   <= '0;
                            r_state       <= ST_IDLE;
                        end else begin
                            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (r_last) begin
                        r_grant       <= 2'b00;
                        r_last_winner <= r_gidx;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_stall_cnt <= '0;
                        r_state     <= ST_SEND;
                    end
                end
                default: begin
                    r_grant <= 2'b00;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data     = r_tx_data;
    assign tx_write_en = r_tx_we;
    assign grant       = r_grant;
    assign stall_err   = r_stall_err;
    assign state_debug = r_state;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: queue-fed requesters, a {grant,byte}
// scoreboard, an arbitration vector table and hand-written corner sequences.
module tb_uart_tx_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       sel   = 1'b0;
    logic [1:0] v_drv = 2'b00;
    logic [1:0] l_drv = 2'b00;
    logic [7:0] d0_drv = 8'h00;
    logic [7:0] d1_drv = 8'h00;
    logic       txr_drv = 1'b1;

    logic [1:0] rv0, rv1;
    logic [1:0] rdy0, rdy1, gnt0, gnt1, st0, st1;
    logic [7:0] txd0, txd1;
    logic       we0, we1, se0, se1;

    assign rv0 = sel ? 2'b00 : v_drv;
    assign rv1 = sel ? v_drv : 2'b00;

    uart_tx_scheduler #(.TIMEOUT_CYCLES(16), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .reset(reset), .req_valid(rv0), .req_data0(d0_drv),
        .req_data1(d1_drv), .req_last(l_drv), .req_ready(rdy0),
        .tx_ready(txr_drv), .tx_data(txd0), .tx_write_en(we0),
        .grant(gnt0), .stall_err(se0), .state_debug(st0)
    );

    uart_tx_scheduler #(.TIMEOUT_CYCLES(16), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_data0(d0_drv),
        .req_data1(d1_drv), .req_last(l_drv), .req_ready(rdy1),
        .tx_ready(txr_drv), .tx_data(txd1), .tx_write_en(we1),
        .grant(gnt1), .stall_err(se1), .state_debug(st1)
    );

    logic [1:0] w_rdy, w_gnt, w_st;
    logic [7:0] w_txd;
    logic       w_we, w_se;
    assign w_rdy = sel ? rdy1 : rdy0;
    assign w_gnt = sel ? gnt1 : gnt0;
    assign w_st  = sel ? st1  : st0;
    assign w_txd = sel ? txd1 : txd0;
    assign w_we  = sel ? we1  : we0;
    assign w_se  = sel ? se1  : se0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_strobe = 0;
    int n_stall = 0;
    int last_strobe_cyc = 0;
    int last_stall_cyc = 0;
    int strobe_cyc_q[$];
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [9:0] exp_q[$];
    logic [1:0] fire = 2'b00;

    typedef struct {
        logic       sel;
        logic       rst;
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       first;
    } vec_t;
    vec_t tbl[10];

    function automatic logic [1:0] oh(input logic i);
        return i ? 2'b10 : 2'b01;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive queue heads, decide handshakes before the edge,
    // then observe outputs at the falling edge and retire accepted bytes.
    task automatic tick();
        v_drv  = {q1.size() != 0, q0.size() != 0};
        d0_drv = 8'h00; d1_drv = 8'h00; l_drv = 2'b00;
        if (q0.size() != 0) begin d0_drv = q0[0][7:0]; l_drv[0] = q0[0][8]; end
        if (q1.size() != 0) begin d1_drv = q1[0][7:0]; l_drv[1] = q1[0][8]; end
        #1;
        fire = v_drv & w_rdy;
        @(negedge clk);
        cyc++;
        if (w_we) begin
            n_strobe++;
            last_strobe_cyc = cyc;
            strobe_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got grant=%b data=0x%0h with nothing expected", w_gnt, w_txd);
            end else begin
                check("tx_grant_byte", {22'd0, w_gnt, w_txd}, {22'd0, exp_q.pop_front()});
            end
        end
        if (w_se) begin
            n_stall++;
            last_stall_cyc = cyc;
        end
        if (fire[0] && q0.size() != 0) void'(q0.pop_front());
        if (fire[1] && q1.size() != 0) void'(q1.pop_front());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        exp_q.delete();
        fire = 2'b00;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && w_st == 2'd0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && w_st == 2'd0)) begin
            errors++;
            $display("FAIL %s_drain: %0d bytes still expected, state=%0d after %0d cycles", name, exp_q.size(), w_st, budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        int s_strobe, s_stall, n;
        logic [1:0] rdy_seen;
        logic       other;

        tbl[0] = '{1'b0, 1'b1, 2'b01, 8'h31, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 2'b11, 8'h42, 8'h43, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 2'b11, 8'h54, 8'h55, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 2'b10, 8'h00, 8'h66, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 2'b11, 8'h77, 8'h78, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 2'b11, 8'h81, 8'h82, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 2'b01, 8'h93, 8'h00, 1'b0};
        tbl[7] = '{1'b1, 1'b0, 2'b11, 8'hA4, 8'hA5, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 2'b10, 8'h00, 8'hB6, 1'b1};
        tbl[9] = '{1'b1, 1'b0, 2'b11, 8'hC7, 8'hC8, 1'b0};

        // Reset state
        sel = 1'b0;
        txr_drv = 1'b1;
        do_reset();
        check("rst_state", {30'd0, w_st}, 32'd0);
        check("rst_grant", {30'd0, w_gnt}, 32'd0);
        check("rst_ready", {30'd0, w_rdy}, 32'd0);
        check("rst_we", {31'd0, w_we}, 32'd0);
        check("rst_txdata", {24'd0, w_txd}, 32'd0);
        check("rst_stall", {31'd0, w_se}, 32'd0);

        // Single three-byte packet from requester 0
        do_reset();
        strobe_cyc_q.delete();
        q0.push_back({1'b0, 8'hA1}); q0.push_back({1'b0, 8'hA2}); q0.push_back({1'b1, 8'hA3});
        exp_q.push_back({2'b01, 8'hA1}); exp_q.push_back({2'b01, 8'hA2}); exp_q.push_back({2'b01, 8'hA3});
        wait_drained("single", 30);
        check("single_count", strobe_cyc_q.size(), 32'd3);
        if (strobe_cyc_q.size() >= 3) begin
            check("single_gap1", strobe_cyc_q[1] - strobe_cyc_q[0], 32'd2);
            check("single_gap2", strobe_cyc_q[2] - strobe_cyc_q[1], 32'd2);
        end
        check("single_idle_grant", {30'd0, w_gnt}, 32'd0);
        check("single_data_hold", {24'd0, w_txd}, 32'h0000_00A3);

        // Round-robin contention: two 2-byte packets each
        do_reset();
        q0.push_back({1'b0, 8'h10}); q0.push_back({1'b1, 8'h11});
        q0.push_back({1'b0, 8'h10}); q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b0, 8'h20}); q1.push_back({1'b1, 8'h21});
        q1.push_back({1'b0, 8'h20}); q1.push_back({1'b1, 8'h21});
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back({2'b01, 8'h10}); exp_q.push_back({2'b01, 8'h11});
            exp_q.push_back({2'b10, 8'h20}); exp_q.push_back({2'b10, 8'h21});
        end
        wait_drained("contend", 80);

        // Backpressure mid-packet for 50 cycles
        do_reset();
        q0.push_back({1'b0, 8'hB1}); q0.push_back({1'b0, 8'hB2}); q0.push_back({1'b1, 8'hB3});
        exp_q.push_back({2'b01, 8'hB1}); exp_q.push_back({2'b01, 8'hB2}); exp_q.push_back({2'b01, 8'hB3});
        s_strobe = n_strobe;
        n = 0;
        while (n_strobe == s_strobe && n < 20) begin tick(); n++; end
        check("bp_first_strobe", n_strobe - s_strobe, 32'd1);
        txr_drv = 1'b0;
        s_strobe = n_strobe;
        s_stall = n_stall;
        rdy_seen = 2'b00;
        repeat (50) begin
            tick();
            rdy_seen |= w_rdy;
        end
        check("bp_no_strobe", n_strobe - s_strobe, 32'd0);
        check("bp_no_stall", n_stall - s_stall, 32'd0);
        check("bp_ready_low", {30'd0, rdy_seen}, 32'd0);
        check("bp_state_send", {30'd0, w_st}, 32'd1);
        txr_drv = 1'b1;
        wait_drained("bp", 20);
        check("bp_strobes_after", n_strobe - s_strobe, 32'd2);
        check("bp_no_stall_end", n_stall - s_stall, 32'd0);

        // Timeout: requester 1 goes silent after one byte, requester 0 waits
        do_reset();
        q1.push_back({1'b0, 8'h55});
        exp_q.push_back({2'b10, 8'h55});
        tick();
        q0.push_back({1'b1, 8'h66});
        exp_q.push_back({2'b01, 8'h66});
        s_stall = n_stall;
        n = 0;
        while (n_stall == s_stall && n < 40) begin tick(); n++; end
        check("to_stall_seen", n_stall - s_stall, 32'd1);
        check("to_stall_delay", last_stall_cyc - last_strobe_cyc, 32'd17);
        check("to_grant_cleared", {30'd0, w_gnt}, 32'd0);
        check("to_state_idle", {30'd0, w_st}, 32'd0);
        wait_drained("timeout", 30);
        repeat (5) tick();
        check("to_stall_once", n_stall - s_stall, 32'd1);

        // Reset while in HOLD on the fixed-priority instance
        sel = 1'b1;
        do_reset();
        q0.push_back({1'b0, 8'hC1}); q0.push_back({1'b1, 8'hC2});
        exp_q.push_back({2'b01, 8'hC1});
        n = 0;
        while (w_st != 2'd2 && n < 10) begin tick(); n++; end
        check("hold_reached", {30'd0, w_st}, 32'd2);
        reset = 1'b1;
        q0.delete();
        exp_q.delete();
        tick();
        reset = 1'b0;
        check("hold_rst_we", {31'd0, w_we}, 32'd0);
        check("hold_rst_grant", {30'd0, w_gnt}, 32'd0);
        check("hold_rst_state", {30'd0, w_st}, 32'd0);

        // Arbitration vectors: one-byte packets, expected winner first
        for (int i = 0; i < 10; i++) begin
            sel = tbl[i].sel;
            if (tbl[i].rst) do_reset();
            if (tbl[i].valid[0]) q0.push_back({1'b1, tbl[i].d0});
            if (tbl[i].valid[1]) q1.push_back({1'b1, tbl[i].d1});
            exp_q.push_back({oh(tbl[i].first), tbl[i].first ? tbl[i].d1 : tbl[i].d0});
            if (tbl[i].valid == 2'b11) begin
                other = ~tbl[i].first;
                exp_q.push_back({oh(other), other ? tbl[i].d1 : tbl[i].d0});
            end
            wait_drained($sformatf("vec%0d", i), 40);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
